// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read/write arbiters.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int LEN_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester strictly after last_grant, wrapping modulo NUM_M.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module rr_arbiter #(
    parameter  int NUM_M = 2,
    localparam int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] next_idx
);

    // Scan from the farthest candidate down to the nearest so the nearest requester wins.
    always_comb begin : pick
        int cand;
        found    = 1'b0;
        next_idx = '0;
        cand     = 0;
        for (int k = NUM_M; k >= 1; k--) begin
            cand = (int'(last_grant) + k) % NUM_M;
            if (req[cand]) begin
                found    = 1'b1;
                next_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between NUM_M masters, round-robin, one read outstanding at a time.
// Latency: one cycle to arbitrate, then AR and R channels are combinational pass-through to the grantee.
// Backpressure: S_ARREADY/M_RREADY of the grantee propagate unchanged; non-granted masters see ready=0.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int NUM_M      = 2,
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_W      = $clog2(NUM_M)
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_M*ADDR_WIDTH-1:0] M_ARADDR,
    input  logic [NUM_M*8-1:0]          M_ARLEN,
    input  logic [NUM_M*3-1:0]          M_ARSIZE,
    input  logic [NUM_M-1:0]            M_ARVALID,
    output logic [NUM_M-1:0]            M_ARREADY,
    output logic [NUM_M*DATA_WIDTH-1:0] M_RDATA,
    output logic [NUM_M*2-1:0]          M_RRESP,
    output logic [NUM_M-1:0]            M_RLAST,
    output logic [NUM_M-1:0]            M_RVALID,
    input  logic [NUM_M-1:0]            M_RREADY,
    output logic [ADDR_WIDTH-1:0]       S_ARADDR,
    output logic [7:0]                  S_ARLEN,
    output logic [2:0]                  S_ARSIZE,
    output logic                        S_ARVALID,
    input  logic                        S_ARREADY,
    input  logic [DATA_WIDTH-1:0]       S_RDATA,
    input  logic [1:0]                  S_RRESP,
    input  logic                        S_RLAST,
    input  logic                        S_RVALID,
    output logic                        S_RREADY,
    output logic [IDX_W-1:0]            GRANT_IDX,
    output logic                        BUSY,
    output logic                        PROTO_ERR
);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len;
    logic             proto_err;
    logic             found;
    logic [IDX_W-1:0] next_idx;
    logic             ar_hs;
    logic             r_hs;

    rr_arbiter #(.NUM_M(NUM_M)) u_rr (
        .req        (M_ARVALID),
        .last_grant (last_grant),
        .found      (found),
        .next_idx   (next_idx)
    );

    assign ar_hs     = (state == ADDR) && M_ARVALID[grant] && S_ARREADY;
    assign r_hs      = (state == DATA) && S_RVALID && M_RREADY[grant];
    assign BUSY      = (state != IDLE);
    assign GRANT_IDX = BUSY ? grant : '0;
    assign PROTO_ERR = proto_err;

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and channel routing; everything is zero while idle.
    always_comb begin
        state_nxt = state;
        M_ARREADY = '0;
        M_RDATA   = '0;
        M_RRESP   = '0;
        M_RLAST   = '0;
        M_RVALID  = '0;
        S_ARADDR  = '0;
        S_ARLEN   = '0;
        S_ARSIZE  = '0;
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                S_ARADDR         = M_ARADDR[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
                S_ARLEN          = M_ARLEN[int'(grant)*8 +: 8];
                S_ARSIZE         = M_ARSIZE[int'(grant)*3 +: 3];
                S_ARVALID        = M_ARVALID[grant];
                M_ARREADY[grant] = S_ARREADY;
                if (ar_hs) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                M_RDATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH] = S_RDATA;
                M_RRESP[int'(grant)*2 +: 2]                   = S_RRESP;
                M_RLAST[grant]                                = S_RLAST;
                M_RVALID[grant]                               = S_RVALID;
                S_RREADY                                      = M_RREADY[grant];
                if (r_hs && S_RLAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, burst length tracking and the sticky protocol-error flag.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            grant      <= '0;
            last_grant <= IDX_W'(NUM_M - 1);
            beat_cnt   <= '0;
            len        <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (state == IDLE && found) begin
                grant <= next_idx;
            end
            if (ar_hs) begin
                len      <= M_ARLEN[int'(grant)*8 +: 8];
                beat_cnt <= '0;
            end
            if (r_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (S_RLAST) begin
                    last_grant <= grant;
                    if (beat_cnt != len) begin
                        proto_err <= 1'b1;
                    end
                end else if (beat_cnt == len) begin
                    // Expected final beat arrived without RLAST; keep waiting for it.
                    proto_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with two masters and a hand-driven slave.
// Latency: checks one-cycle arbitration and zero-latency R pass-through.
// Backpressure: exercises master-side R stalls and slave AR stalls.
module tb_axi_rd_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] M_ARADDR;
    logic [15:0] M_ARLEN;
    logic [5:0]  M_ARSIZE;
    logic [1:0]  M_ARVALID;
    logic [1:0]  M_ARREADY;
    logic [63:0] M_RDATA;
    logic [3:0]  M_RRESP;
    logic [1:0]  M_RLAST;
    logic [1:0]  M_RVALID;
    logic [1:0]  M_RREADY;
    logic [15:0] S_ARADDR;
    logic [7:0]  S_ARLEN;
    logic [2:0]  S_ARSIZE;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RLAST;
    logic        S_RVALID;
    logic        S_RREADY;
    logic        GRANT_IDX;
    logic        BUSY;
    logic        PROTO_ERR;

    int total = 0;
    int bad   = 0;

    always #5 ACLK = ~ACLK;

    axi_rd_arbiter #(.NUM_M(2), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .M_ARADDR  (M_ARADDR),
        .M_ARLEN   (M_ARLEN),
        .M_ARSIZE  (M_ARSIZE),
        .M_ARVALID (M_ARVALID),
        .M_ARREADY (M_ARREADY),
        .M_RDATA   (M_RDATA),
        .M_RRESP   (M_RRESP),
        .M_RLAST   (M_RLAST),
        .M_RVALID  (M_RVALID),
        .M_RREADY  (M_RREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARLEN   (S_ARLEN),
        .S_ARSIZE  (S_ARSIZE),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RLAST   (S_RLAST),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY),
        .GRANT_IDX (GRANT_IDX),
        .BUSY      (BUSY),
        .PROTO_ERR (PROTO_ERR)
    );

    task automatic step;
        @(posedge ACLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_arvalid"}, 64'(S_ARVALID), 64'd0);
        chk({tag, "_araddr"},  64'(S_ARADDR),  64'd0);
        chk({tag, "_rready"},  64'(S_RREADY),  64'd0);
        chk({tag, "_m_arrdy"}, 64'(M_ARREADY), 64'd0);
        chk({tag, "_m_rvld"},  64'(M_RVALID),  64'd0);
        chk({tag, "_m_rdata"}, M_RDATA,        64'd0);
        chk({tag, "_busy"},    64'(BUSY),      64'd0);
        chk({tag, "_perr"},    64'(PROTO_ERR), 64'd0);
        chk({tag, "_grant"},   64'(GRANT_IDX), 64'd0);
    endtask

    // Master m issues one read; the slave returns beats base+b, RLAST on beat last_at.
    // Optional R stall of stall_n cycles at beat stall_at, and optional reset at beat abort_at.
    task automatic read_txn(input int m, input logic [15:0] addr, input logic [7:0] len,
                            input int last_at, input int stall_at, input int stall_n,
                            input int abort_at, input logic [31:0] base, input logic [1:0] resp);
        logic [63:0] exp_d;
        logic [3:0]  exp_r;
        M_ARADDR[m*16 +: 16] = addr;
        M_ARLEN[m*8 +: 8]    = len;
        M_ARSIZE[m*3 +: 3]   = 3'd2;
        M_ARVALID[m]         = 1'b1;
        #1;
        chk("idle_s_arvalid", 64'(S_ARVALID), 64'd0);
        chk("idle_busy", 64'(BUSY), 64'd0);
        step;
        chk("addr_grant", 64'(GRANT_IDX), 64'(m));
        chk("addr_s_arvalid", 64'(S_ARVALID), 64'd1);
        chk("addr_s_araddr", 64'(S_ARADDR), 64'(addr));
        chk("addr_s_arlen", 64'(S_ARLEN), 64'(len));
        chk("addr_s_arsize", 64'(S_ARSIZE), 64'd2);
        chk("addr_m_arready_wait", 64'(M_ARREADY), 64'd0);
        chk("addr_busy", 64'(BUSY), 64'd1);
        S_ARREADY = 1'b1;
        #1;
        chk("addr_m_arready", 64'(M_ARREADY), 64'd1 << m);
        step;
        M_ARVALID[m] = 1'b0;
        S_ARREADY    = 1'b0;
        chk("data_busy", 64'(BUSY), 64'd1);
        chk("data_s_arvalid", 64'(S_ARVALID), 64'd0);
        for (int b = 0; b <= last_at; b++) begin
            S_RVALID = 1'b1;
            S_RDATA  = base + 32'(b);
            S_RRESP  = resp;
            S_RLAST  = (b == last_at);
            if (b == abort_at) begin
                ARESET = 1'b1;
                step;
                ARESET   = 1'b0;
                S_RVALID = 1'b0;
                S_RLAST  = 1'b0;
                return;
            end
            if (b == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    M_RREADY[m] = 1'b0;
                    #1;
                    chk("stall_s_rready", 64'(S_RREADY), 64'd0);
                    chk("stall_m_rvalid", 64'(M_RVALID), 64'd1 << m);
                    step;
                end
            end
            M_RREADY[m] = 1'b1;
            #1;
            exp_d = '0;
            exp_d[m*32 +: 32] = base + 32'(b);
            exp_r = '0;
            exp_r[m*2 +: 2] = resp;
            chk("beat_m_rdata", M_RDATA, exp_d);
            chk("beat_m_rresp", 64'(M_RRESP), 64'(exp_r));
            chk("beat_m_rvalid", 64'(M_RVALID), 64'd1 << m);
            chk("beat_m_rlast", 64'(M_RLAST), (b == last_at) ? (64'd1 << m) : 64'd0);
            chk("beat_s_rready", 64'(S_RREADY), 64'd1);
            step;
        end
        S_RVALID = 1'b0;
        S_RLAST  = 1'b0;
        #1;
        chk("done_busy", 64'(BUSY), 64'd0);
        chk("done_m_rvalid", 64'(M_RVALID), 64'd0);
    endtask

    initial begin
        ARESET    = 1'b1;
        M_ARADDR  = '0;
        M_ARLEN   = '0;
        M_ARSIZE  = '0;
        M_ARVALID = '0;
        M_RREADY  = 2'b11;
        S_ARREADY = 1'b0;
        S_RDATA   = '0;
        S_RRESP   = '0;
        S_RLAST   = 1'b0;
        S_RVALID  = 1'b0;

        // Reset held two cycles with random requests and a live slave R channel.
        for (int i = 0; i < 2; i++) begin
            M_ARVALID = 2'($urandom_range(0, 3));
            S_RVALID  = 1'b1;
            S_RDATA   = $urandom;
            step;
            chk_all_zero("reset");
        end
        M_ARVALID = '0;
        S_RVALID  = 1'b0;
        S_RDATA   = '0;
        ARESET    = 1'b0;

        // Single read from master 0.
        read_txn(0, 16'h0010, 8'd3, 3, -1, 0, -1, 32'hA0, 2'b00);
        chk("single_perr", 64'(PROTO_ERR), 64'd0);

        // Fresh reset so contention starts from last_grant = NUM_M-1.
        ARESET = 1'b1;
        step;
        ARESET = 1'b0;

        // Contention: both masters request; order must be 0,1,0,1.
        M_ARADDR[16 +: 16] = 16'h0110;
        M_ARLEN[8 +: 8]    = 8'd1;
        M_ARVALID[1]       = 1'b1;
        read_txn(0, 16'h0100, 8'd1, 1, -1, 0, -1, 32'h10, 2'b00);
        read_txn(1, 16'h0110, 8'd1, 1, -1, 0, -1, 32'h20, 2'b00);
        M_ARVALID[1] = 1'b1;
        read_txn(0, 16'h0120, 8'd1, 1, -1, 0, -1, 32'h30, 2'b00);
        read_txn(1, 16'h0110, 8'd1, 1, -1, 0, -1, 32'h40, 2'b00);

        // Backpressure: master 1 stalls 3 cycles at beat 4 of an 8-beat burst.
        read_txn(1, 16'h0200, 8'd7, 7, 4, 3, -1, 32'hB0, 2'b00);
        chk("bp_perr", 64'(PROTO_ERR), 64'd0);

        // Early RLAST on a 4-beat burst flags a protocol error.
        read_txn(0, 16'h0300, 8'd3, 2, -1, 0, -1, 32'hC0, 2'b10);
        chk("perr_set", 64'(PROTO_ERR), 64'd1);
        chk("perr_idle", 64'(BUSY), 64'd0);

        // A well-formed single beat completes; the error stays sticky.
        read_txn(0, 16'h0304, 8'd0, 0, -1, 0, -1, 32'hD0, 2'b00);
        chk("perr_sticky", 64'(PROTO_ERR), 64'd1);

        // Reset during beat 2 of an 8-beat burst from master 1.
        read_txn(1, 16'h0400, 8'd7, 7, -1, 0, 2, 32'hE0, 2'b00);
        #1;
        chk_all_zero("midrst");

        // After reset master 0 must win against master 1.
        M_ARADDR[16 +: 16] = 16'h0510;
        M_ARLEN[8 +: 8]    = 8'd0;
        M_ARVALID[1]       = 1'b1;
        read_txn(0, 16'h0500, 8'd0, 0, -1, 0, -1, 32'hF0, 2'b00);
        read_txn(1, 16'h0510, 8'd0, 0, -1, 0, -1, 32'hF8, 2'b00);
        chk("final_perr", 64'(PROTO_ERR), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
